// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register for an RV32 core.
// Selects and extracts the write-back data at capture time, holds the
// instruction under stall, squashes it under flush, and counts retired
// instructions. The register-file write enable is decoded combinationally
// from the captured state.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rf_we,
  input  logic [1:0]  mem_wd_sel,
  input  logic [2:0]  mem_ld_type,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_dram_rd,
  input  logic [31:0] mem_pc4,
  input  logic [31:0] mem_imm,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  wR,
  output logic [31:0] wD,
  output logic        we,
  output logic        wb_valid,
  output logic [31:0] instret
);

  // Load extraction: pick the byte/halfword addressed by the low address
  // bits and extend it. Unknown funct3 values fall back to the full word.
  function automatic logic [31:0] f_load_ext(
    input logic [2:0]  ld_type,
    input logic [1:0]  offset,
    input logic [31:0] word
  );
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    logic [31:0] v_res;
    case (offset)
      2'd0:    v_byte = word[7:0];
      2'd1:    v_byte = word[15:8];
      2'd2:    v_byte = word[23:16];
      2'd3:    v_byte = word[31:24];
      default: v_byte = word[7:0];
    endcase
    v_half = offset[1] ? word[31:16] : word[15:0];
    case (ld_type)
      3'b000:  v_res = {{24{v_byte[7]}}, v_byte};
      3'b001:  v_res = {{16{v_half[15]}}, v_half};
      3'b100:  v_res = {24'd0, v_byte};
      3'b101:  v_res = {16'd0, v_half};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  logic [31:0] w_wd_next;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic        r_rf_we;
  logic [31:0] r_wd;
  logic [31:0] r_instret;

  // Write-data source select; a bubble always carries zero data.
  always_comb begin
    w_wd_next = 32'd0;
    if (mem_valid) begin
      case (mem_wd_sel)
        2'b00:   w_wd_next = mem_alu_res;
        2'b01:   w_wd_next = f_load_ext(mem_ld_type, mem_alu_res[1:0], mem_dram_rd);
        2'b10:   w_wd_next = mem_pc4;
        2'b11:   w_wd_next = mem_imm;
        default: w_wd_next = 32'd0;
      endcase
    end else begin
      w_wd_next = 32'd0;
    end
  end

  // Pipeline register: flush beats stall beats capture; instret counts
  // each real instruction exactly once, when it is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rd      <= 5'd0;
      r_rf_we   <= 1'b0;
      r_wd      <= 32'd0;
      r_instret <= 32'd0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_rd      <= 5'd0;
      r_rf_we   <= 1'b0;
      r_wd      <= 32'd0;
    end else if (!stall) begin
      r_valid   <= mem_valid;
      r_rd      <= mem_rd;
      r_rf_we   <= mem_rf_we;
      r_wd      <= w_wd_next;
      r_instret <= r_instret + {31'd0, mem_valid};
    end
  end

  assign wR       = r_rd;
  assign wD       = r_wd;
  assign wb_valid = r_valid;
  assign instret  = r_instret;
  // x0 is hard-wired to zero, so writes to it are suppressed here.
  assign we       = r_valid & r_rf_we & (r_rd != 5'd0);

endmodule
